// File: rtl/simd_sat_stage_pkg.sv
// Shared definitions for the SIMD saturation stage: mode encodings,
// lane/buffer enums and the helpers that map 16-bit chunks onto lanes.
`ifndef SIMD_WIDTH
`define SIMD_WIDTH 2
`endif

package simd_sat_stage_pkg;

   // Encodings of in_simd_ctl (bit 0 wins when both are set)
   localparam logic [`SIMD_WIDTH-1:0] SIMD_2X32 = `SIMD_WIDTH'('b01);
   localparam logic [`SIMD_WIDTH-1:0] SIMD_4X16 = `SIMD_WIDTH'('b10);

   typedef enum logic [1:0] {
      MODE_1X64 = 2'd0,
      MODE_2X32 = 2'd1,
      MODE_4X16 = 2'd2
   } lane_mode_e;

   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_FULL1 = 2'd1,
      BUF_FULL2 = 2'd2
   } buf_state_e;

   // Resolve the effective lane mode; 2x32 has priority over 4x16.
   function automatic lane_mode_e decode_mode(input logic simd_ena,
                                              input logic [`SIMD_WIDTH-1:0] ctl);
      if (simd_ena && ((ctl & SIMD_2X32) != '0)) return MODE_2X32;
      if (simd_ena && ((ctl & SIMD_4X16) != '0)) return MODE_4X16;
      return MODE_1X64;
   endfunction

   // The 16-bit chunk whose MSB is the sign/carry bit of the lane that
   // contains the given chunk.
   function automatic logic [1:0] lane_owner(input lane_mode_e mode,
                                             input logic [1:0] chunk);
      case (mode)
         MODE_2X32: return {chunk[1], 1'b1};
         MODE_4X16: return chunk;
         default:   return 2'd3;
      endcase
   endfunction

endpackage

// File: rtl/simd_sat_stage_sat_lane_detect.sv
// Overflow detection for a single lane from the operand and sum MSBs,
// plus the direction in which the lane must saturate.
module sat_lane_detect (
   input  logic am,
   input  logic bm,
   input  logic sm,
   input  logic sub,
   input  logic sat_signed,
   output logic ov,
   output logic sat_hi
);

   logic signed_ov;
   logic carry_out;
   logic unsigned_ov;

   // Signed overflow: same-sign operands with a sign flip in the sum.
   // Unsigned: carry-out for add, borrow (no carry) for subtract.
   always_comb begin
      signed_ov   = (am == bm) && (sm != am);
      carry_out   = (am & bm) | ((am | bm) & ~sm);
      unsigned_ov = sub ? ~carry_out : carry_out;
      ov          = sat_signed ? signed_ov : unsigned_ov;
      sat_hi      = sat_signed ? ~am : ~sub;
   end

endmodule

// File: rtl/simd_sat_stage.sv
// Saturation stage behind the SIMD adder: per-lane clamp on the input
// side, 1-cycle registered output with a 2-entry skid buffer, and a
// sticky overflow flag for CSR readout.
`ifndef SIMD_WIDTH
`define SIMD_WIDTH 2
`endif

module simd_sat_stage
   import simd_sat_stage_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int LANE_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_W-1:0]      in_a,
   input  logic [DATA_W-1:0]      in_b,
   input  logic [DATA_W-1:0]      in_s,
   input  logic                   in_sub,
   input  logic                   in_sat_ena,
   input  logic                   in_sat_signed,
   input  logic                   in_simd_ena,
   input  logic [`SIMD_WIDTH-1:0] in_simd_ctl,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_W-1:0]      out_data,
   output logic                   out_ov,
   input  logic                   ov_clr,
   output logic                   ov_sticky
);

   localparam int NUM_CHUNKS = DATA_W / LANE_W;

   lane_mode_e              mode;
   logic [NUM_CHUNKS-1:0]   chunk_det_ov;
   logic [NUM_CHUNKS-1:0]   chunk_det_hi;
   logic [NUM_CHUNKS-1:0]   chunk_sat;
   logic [DATA_W-1:0]       res_data;
   logic                    res_ov;

   buf_state_e              state_reg, state_next;
   logic [DATA_W-1:0]       out_data_reg, skid_data_reg;
   logic                    out_ov_reg, skid_ov_reg;
   logic                    sticky_reg;
   logic                    load_out_in, load_out_skid, load_skid;
   logic                    accept, drain, accept_live;

   // Only lane MSBs of the operands matter; the rest is folded away here.
   logic                    unused_operand_bits;
   assign unused_operand_bits = ^{in_a, in_b};

   assign mode = decode_mode(in_simd_ena, in_simd_ctl);

   genvar gi;

   // One detector per 16-bit chunk MSB; the mode picks which ones govern.
   generate
      for (gi = 0; gi < NUM_CHUNKS; gi++) begin : g_detect
         sat_lane_detect u_detect (
            .am         (in_a[gi*LANE_W + LANE_W-1]),
            .bm         (in_b[gi*LANE_W + LANE_W-1]),
            .sm         (in_s[gi*LANE_W + LANE_W-1]),
            .sub        (in_sub),
            .sat_signed (in_sat_signed),
            .ov         (chunk_det_ov[gi]),
            .sat_hi     (chunk_det_hi[gi])
         );
      end
   endgenerate

   // Each chunk takes the verdict of its lane's top chunk; only the top
   // chunk of a signed lane gets the inverted sign bit.
   generate
      for (gi = 0; gi < NUM_CHUNKS; gi++) begin : g_chunk
         logic [1:0]        owner;
         logic              hi;
         logic [LANE_W-1:0] sat_val;
         always_comb begin
            owner   = lane_owner(mode, 2'(gi));
            hi      = chunk_det_hi[owner];
            sat_val = {LANE_W{hi}};
            if (owner == 2'(gi) && in_sat_signed) begin
               sat_val[LANE_W-1] = ~hi;
            end
            chunk_sat[gi] = in_sat_ena & chunk_det_ov[owner];
            res_data[gi*LANE_W +: LANE_W] = chunk_sat[gi] ? sat_val
                                                          : in_s[gi*LANE_W +: LANE_W];
         end
      end
   endgenerate

   assign res_ov      = |chunk_sat;
   assign accept      = in_valid & in_ready;
   assign drain       = out_valid & out_ready;
   assign accept_live = accept & ~flush;

   // Buffer state register
   always_ff @(posedge clk) begin
      if (!rst_n) state_reg <= BUF_EMPTY;
      else        state_reg <= state_next;
   end

   // Next state and load strobes for the output and skid registers
   always_comb begin
      state_next    = state_reg;
      load_out_in   = 1'b0;
      load_out_skid = 1'b0;
      load_skid     = 1'b0;
      if (flush) begin
         state_next = BUF_EMPTY;
      end else begin
         case (state_reg)
            BUF_EMPTY: begin
               if (accept) begin
                  state_next  = BUF_FULL1;
                  load_out_in = 1'b1;
               end
            end
            BUF_FULL1: begin
               if (accept && drain) begin
                  load_out_in = 1'b1;
               end else if (accept) begin
                  state_next = BUF_FULL2;
                  load_skid  = 1'b1;
               end else if (drain) begin
                  state_next = BUF_EMPTY;
               end
            end
            BUF_FULL2: begin
               if (drain) begin
                  state_next    = BUF_FULL1;
                  load_out_skid = 1'b1;
               end
            end
            default: state_next = BUF_EMPTY;
         endcase
      end
   end

   // Output and skid data registers; output holds unless reloaded
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_data_reg  <= '0;
         out_ov_reg    <= 1'b0;
         skid_data_reg <= '0;
         skid_ov_reg   <= 1'b0;
      end else begin
         if (load_out_in) begin
            out_data_reg <= res_data;
            out_ov_reg   <= res_ov;
         end else if (load_out_skid) begin
            out_data_reg <= skid_data_reg;
            out_ov_reg   <= skid_ov_reg;
         end
         if (load_skid) begin
            skid_data_reg <= res_data;
            skid_ov_reg   <= res_ov;
         end
      end
   end

   // Sticky overflow: a saturating accept wins over a same-cycle clear
   always_ff @(posedge clk) begin
      if (!rst_n)                     sticky_reg <= 1'b0;
      else if (accept_live && res_ov) sticky_reg <= 1'b1;
      else if (ov_clr)                sticky_reg <= 1'b0;
   end

   assign in_ready  = (state_reg != BUF_FULL2);
   assign out_valid = (state_reg != BUF_EMPTY);
   assign out_data  = out_data_reg;
   assign out_ov    = out_ov_reg;
   assign ov_sticky = sticky_reg;

endmodule

// File: tb/tb_simd_sat_stage.sv
// Directed bench for simd_sat_stage: vector table for the saturation
// datapath, hand sequences for backpressure, flush, sticky and reset.
`ifndef SIMD_WIDTH
`define SIMD_WIDTH 2
`endif

module tb_simd_sat_stage;

   logic                   clk;
   logic                   rst_n;
   logic                   flush;
   logic                   in_valid;
   logic                   in_ready;
   logic [63:0]            in_a, in_b, in_s;
   logic                   in_sub, in_sat_ena, in_sat_signed, in_simd_ena;
   logic [`SIMD_WIDTH-1:0] in_simd_ctl;
   logic                   out_valid;
   logic                   out_ready;
   logic [63:0]            out_data;
   logic                   out_ov;
   logic                   ov_clr;
   logic                   ov_sticky;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [63:0] a, b, s;
      logic        sub, sat_ena, sat_signed, simd_ena;
      logic [1:0]  ctl;
      logic [63:0] exp_data;
      logic        exp_ov;
   } vec_t;

   localparam int NV = 10;
   vec_t vecs[NV];
   vec_t pa, pb, pc;

   simd_sat_stage dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_a          (in_a),
      .in_b          (in_b),
      .in_s          (in_s),
      .in_sub        (in_sub),
      .in_sat_ena    (in_sat_ena),
      .in_sat_signed (in_sat_signed),
      .in_simd_ena   (in_simd_ena),
      .in_simd_ctl   (in_simd_ctl),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_ov        (out_ov),
      .ov_clr        (ov_clr),
      .ov_sticky     (ov_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      in_a          = v.a;
      in_b          = v.b;
      in_s          = v.s;
      in_sub        = v.sub;
      in_sat_ena    = v.sat_ena;
      in_sat_signed = v.sat_signed;
      in_simd_ena   = v.simd_ena;
      in_simd_ctl   = `SIMD_WIDTH'(v.ctl);
   endtask

   initial begin
      //              a                      b                      s                      sub sat sgn simd ctl   exp_data               ov
      vecs[0] = '{64'h7FFF_0001_8000_0005, 64'h0001_0001_FFFF_0003, 64'h8000_0002_7FFF_0008, 0, 1, 1, 1, 2'b10, 64'h7FFF_0002_8000_0008, 1};
      vecs[1] = '{64'h0000_0009_0000_0005, 64'hFFFF_FFFE_FFFF_FFF8, 64'h0000_0008_FFFF_FFFE, 1, 1, 0, 1, 2'b01, 64'h0000_0008_0000_0000, 1};
      vecs[2] = '{64'h0000_0009_0000_0005, 64'hFFFF_FFFE_FFFF_FFF8, 64'h0000_0008_FFFF_FFFE, 1, 0, 0, 1, 2'b01, 64'h0000_0008_FFFF_FFFE, 0};
      vecs[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000, 0, 1, 1, 0, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 1};
      vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001, 0, 1, 0, 0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 1};
      vecs[5] = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFE, 64'h7FFF_FFFF_FFFF_FFFF, 1, 1, 1, 0, 2'b00, 64'h8000_0000_0000_0000, 1};
      vecs[6] = '{64'h0000_7FFF_0000_0000, 64'h0000_0001_0000_0000, 64'h0000_8000_0000_0000, 0, 1, 1, 1, 2'b11, 64'h0000_8000_0000_0000, 0};
      vecs[7] = '{64'h7FFF_0001_8000_0005, 64'h0001_0001_FFFF_0003, 64'h8000_0002_7FFF_0008, 0, 1, 1, 0, 2'b10, 64'h7FFF_FFFF_FFFF_FFFF, 1};
      vecs[8] = '{64'h0001_0002_0003_0004, 64'h0001_0001_0001_0001, 64'h0002_0003_0004_0005, 0, 1, 0, 1, 2'b10, 64'h0002_0003_0004_0005, 0};
      vecs[9] = '{64'h0000_0000_0000_0003, 64'hFFFF_FFFF_FFFF_FFFA, 64'h0000_0000_0000_FFFE, 1, 1, 0, 1, 2'b10, 64'h0000_0000_0000_0000, 1};
      pa = '{64'h0, 64'h0, 64'h1111_2222_3333_4444, 0, 0, 0, 0, 2'b00, 64'h1111_2222_3333_4444, 0};
      pb = '{64'h0, 64'h0, 64'h5555_6666_7777_8888, 0, 0, 0, 0, 2'b00, 64'h5555_6666_7777_8888, 0};
      pc = '{64'h0, 64'h0, 64'h9999_AAAA_BBBB_CCCC, 0, 0, 0, 0, 2'b00, 64'h9999_AAAA_BBBB_CCCC, 0};

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ov_clr = 1'b0;
      drive(pa);
      repeat (2) @(posedge clk);
      #1;
      check("reset out_valid", 64'(out_valid), 64'd0);
      check("reset out_data",  out_data,        64'd0);
      check("reset out_ov",    64'(out_ov),    64'd0);
      check("reset ov_sticky", 64'(ov_sticky), 64'd0);
      check("reset in_ready",  64'(in_ready),  64'd1);
      @(negedge clk); rst_n = 1'b1;

      // Vector table: clear sticky, then one accept per vector
      for (int i = 0; i < NV; i++) begin
         @(negedge clk); in_valid = 1'b0; ov_clr = 1'b1;
         @(negedge clk); ov_clr = 1'b0; drive(vecs[i]); in_valid = 1'b1;
         @(posedge clk); #1;
         in_valid = 1'b0;
         check($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'd1);
         check($sformatf("vec%0d out_data", i),  out_data,        vecs[i].exp_data);
         check($sformatf("vec%0d out_ov", i),    64'(out_ov),    64'(vecs[i].exp_ov));
         check($sformatf("vec%0d ov_sticky", i), 64'(ov_sticky), 64'(vecs[i].exp_ov));
         $display("[TB] vec%0d data=%h ov=%0d", i, out_data, out_ov);
      end
      @(negedge clk); in_valid = 1'b0;
      @(posedge clk); #1;
      check("drain to empty", 64'(out_valid), 64'd0);

      // Backpressure: three back-to-back valids against a stalled output
      @(negedge clk); out_ready = 1'b0; drive(pa); in_valid = 1'b1;
      @(posedge clk); #1;
      check("bp in_ready after 1st", 64'(in_ready), 64'd1);
      @(negedge clk); drive(pb);
      @(posedge clk); #1;
      check("bp in_ready after 2nd", 64'(in_ready), 64'd0);
      check("bp head data", out_data, pa.s);
      @(negedge clk); drive(pc);
      repeat (3) begin
         @(posedge clk); #1;
         check("bp stall data",     out_data,         pa.s);
         check("bp stall in_ready", 64'(in_ready),  64'd0);
      end
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp drain 1 data",  out_data,        pb.s);
      check("bp drain 1 valid", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp drain 2 data", out_data, pc.s);
      @(posedge clk); #1;
      check("bp drained empty", 64'(out_valid), 64'd0);
      $display("[TB] backpressure sequence done");

      // Flush in FULL2 with a saturating input pending
      @(negedge clk); ov_clr = 1'b1;
      @(negedge clk); ov_clr = 1'b0; out_ready = 1'b0; drive(pa); in_valid = 1'b1;
      @(negedge clk); drive(pb);
      @(posedge clk); #1;
      check("flush pre in_ready", 64'(in_ready), 64'd0);
      @(negedge clk); drive(vecs[0]); flush = 1'b1;
      @(posedge clk); #1;
      check("flush full2 out_valid", 64'(out_valid), 64'd0);
      check("flush full2 in_ready",  64'(in_ready),  64'd1);
      check("flush full2 sticky",    64'(ov_sticky), 64'd0);
      // Flush from EMPTY: a saturating input that would be accepted is dropped
      @(posedge clk); #1;
      check("flush empty out_valid", 64'(out_valid), 64'd0);
      check("flush empty sticky",    64'(ov_sticky), 64'd0);
      $display("[TB] flush sequence done");

      // Sticky priority: set beats clear, clear alone clears, flush keeps it
      @(negedge clk); flush = 1'b0; out_ready = 1'b1; drive(vecs[0]); in_valid = 1'b1; ov_clr = 1'b1;
      @(posedge clk); #1;
      check("sticky set over clr", 64'(ov_sticky), 64'd1);
      @(negedge clk); in_valid = 1'b0; ov_clr = 1'b1;
      @(posedge clk); #1;
      check("sticky clr alone", 64'(ov_sticky), 64'd0);
      @(negedge clk); ov_clr = 1'b0; in_valid = 1'b1;
      @(negedge clk); in_valid = 1'b0; flush = 1'b1;
      @(posedge clk); #1;
      check("sticky kept by flush", 64'(ov_sticky), 64'd1);
      check("flush full1 out_valid", 64'(out_valid), 64'd0);
      $display("[TB] sticky sequence done");

      // Reset mid-stall with both entries occupied
      @(negedge clk); flush = 1'b0; out_ready = 1'b0; drive(vecs[0]); in_valid = 1'b1;
      @(negedge clk); drive(vecs[3]);
      @(negedge clk); in_valid = 1'b0; rst_n = 1'b0;
      @(posedge clk); #1;
      check("midreset out_valid", 64'(out_valid), 64'd0);
      check("midreset out_data",  out_data,        64'd0);
      check("midreset out_ov",    64'(out_ov),    64'd0);
      check("midreset sticky",    64'(ov_sticky), 64'd0);
      check("midreset in_ready",  64'(in_ready),  64'd1);
      @(negedge clk); rst_n = 1'b1; out_ready = 1'b1; drive(vecs[8]); in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("post reset data", out_data, vecs[8].exp_data);
      @(posedge clk); #1;
      check("post reset no stale", 64'(out_valid), 64'd0);
      $display("[TB] reset sequence done");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/simd_sat_stage.md
Name: simd_sat_stage

Overview:
- Pipeline stage directly downstream of the SIMD adder in the execute unit.
- Consumes the adder's 64-bit sum plus the operand MSBs it was fed, and applies per-lane saturation (signed or unsigned) for the 64x1, 2x32 and 4x16 modes.
- Registers the result behind a valid/ready handshake with a 2-entry skid buffer.
- Maintains a sticky overflow flag (vxsat-style) for CSR readout.

Parameters:
- DATA_W, 64, datapath width; fixed at 64, lanes derived from it.
- LANE_W, 16, smallest lane width; the lane mask granularity.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous reset, active-low
- flush  in  1  pipeline flush; drops buffered results
- in_valid  in  1  upstream result valid
- in_ready  out  1  stage can accept this cycle
- in_a  in  64  operand a as fed to the adder
- in_b  in  64  operand b as fed to the adder (already inverted for subtract)
- in_s  in  64  adder sum
- in_sub  in  1  operation was a subtract (b inverted, ci=1)
- in_sat_ena  in  1  saturate this result; 0 = pass-through wrap
- in_sat_signed  in  1  1 = signed saturation, 0 = unsigned
- in_simd_ena  in  1  SIMD mode enable
- in_simd_ctl  in  `SIMD_WIDTH  'b01 2x32, 'b10 4x16, else 1x64
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_data  out  64  final (possibly saturated) result
- out_ov  out  1  this result saturated in at least one lane
- ov_clr  in  1  clear sticky flag (CSR write)
- ov_sticky  out  1  sticky overflow flag

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - out_valid=0, out_data=0, out_ov=0, ov_sticky=0.
  - Both buffer entries are empty, so in_ready=1 in the first cycle after reset.
  - Reset mid-transfer discards all entries.
- Lane mode:
  - ctl[0]&simd_ena gives 32-bit lanes, at bits 31 and 63.
  - ctl[1]&simd_ena gives 16-bit lanes, at bits 15/31/47/63.
  - Otherwise one 64-bit lane.
  - ctl[0] has priority when both bits are set.
- Per lane, with MSBs am, bm, sm:
  - signed overflow = (am==bm) && (sm!=am).
  - carry-out = (am&bm) | ((am|bm)&~sm).
  - unsigned overflow = carry-out when in_sub=0, and ~carry-out when in_sub=1.
- Saturated value per lane:
  - Signed: overflow with am=0 gives 0111..1; with am=1 gives 1000..0.
  - Unsigned add: all ones.
  - Unsigned sub: all zeros.
  - A non-overflowing lane passes in_s unchanged.
- If in_sat_ena=0, out_data=in_s and out_ov=0.
- Saturation logic is combinational on the input side; results are registered.
- Latency: 1 cycle. A transfer accepted at edge N is visible at out_* after edge N when the buffer was empty.
- Handshake:
  - Transfer occurs on in_valid&in_ready, and on out_valid&out_ready.
  - in_ready is a registered signal: it is 1 iff the skid entry is empty.
  - Data order is preserved (FIFO).
  - out_data/out_ov are held stable while out_valid&!out_ready.
- Buffer states:
  - EMPTY: accept goes to FULL1.
  - FULL1: accept without drain goes to FULL2 and in_ready drops. Accept with drain stays in FULL1. Drain without accept goes to EMPTY.
  - FULL2: drain goes to FULL1 and the skid entry moves to the output. No accept is possible.
- flush:
  - Next state is EMPTY and out_valid=0.
  - An input presented in the same cycle is dropped.
  - ov_sticky is unaffected.
- Sticky flag:
  - Set on an accepted input whose result saturated.
  - Priority: set > ov_clr when both occur in the same cycle.
  - Not set by a flushed-in-same-cycle input.
- Lanes never interact; only MSBs of each lane are inspected.

Decomposition:
- Shared package/include: `SIMD_WIDTH, and mode encodings SIMD_2X32='b01, SIMD_4X16='b10.
- Sub-module sat_lane_detect:
  - Inputs: am, bm, sm, sub, signed.
  - Outputs: ov, and sat_hi (1 = saturate to max).
  - Instantiated once per 16-bit lane position; the stage selects which positions are active per mode.

Test Plan:
1. 4x16 signed add, a=0x7FFF_0001_8000_0005, b=0x0001_0001_FFFF_0003, s from adder, sat_ena=1 -> out_data=0x7FFF_0002_8000_0008, out_ov=1, ov_sticky=1 next cycle.
2. 2x32 unsigned sub (in_sub=1), 5-7 in lane0 and 9-1 in lane1 -> lane0=0x0000_0000, lane1=0x0000_0008, out_ov=1. The same op with sat_ena=0 -> lane0=0xFFFF_FFFE, out_ov=0.
3. Backpressure: out_ready=0 with 3 back-to-back valids -> in_ready drops after the 2nd accept, the third is held upstream. out_ready=1 then drains the results in order with no loss or duplication, and out_data is stable while stalled.
4. flush asserted while in FULL2 with in_valid=1 -> next cycle out_valid=0, in_ready=1; ov_sticky retains its prior value.
5. ov_clr asserted in the same cycle as a saturating accept -> ov_sticky=1. ov_clr alone -> 0 next cycle.
6. rst_n=0 mid-stall with valid data buffered -> all outputs 0, in_ready=1 after the reset edge.
